// File: rtl/mul4_pkg.sv
// Shared types and constants for the 4x4 multiplier job controller.
package mul4_pkg;

  localparam int OPW = 4;
  localparam int PW  = 8;
  localparam int TOW = 8;  // watchdog counter width, covers TIMEOUT up to 255

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/mul4_op_fifo.sv
// Small operand-pair FIFO; head is readable combinationally so a pop can load operands directly.
module mul4_op_fifo
  import mul4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  op_pair_t push_data,
  input  logic     pop,
  output op_pair_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  op_pair_t       mem [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic           do_push;
  logic           do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          mem[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mul4_job_ctrl.sv
// Job controller: queues operand pairs, sequences the shift-add multiplier, and
// presents products (or watchdog aborts) on a valid/ready result port.
module mul4_job_ctrl
  import mul4_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  output logic           mul_start,
  output logic [OPW-1:0] mul_a,
  output logic [OPW-1:0] mul_b,
  input  logic [PW-1:0]  mul_p,
  input  logic           mul_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PW-1:0]  out_p,
  output logic           out_err,
  output logic           busy
);

  localparam logic [TOW-1:0] TIMEOUT_CNT = TOW'(TIMEOUT);

  state_t         state_reg, state_next;
  logic [TOW-1:0] cnt_reg, cnt_next;
  logic [OPW-1:0] mul_a_reg, mul_a_next;
  logic [OPW-1:0] mul_b_reg, mul_b_next;
  logic           out_valid_reg, out_valid_next;
  logic [PW-1:0]  out_p_reg, out_p_next;
  logic           out_err_reg, out_err_next;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  op_pair_t       fifo_in;
  op_pair_t       fifo_head;
  logic           slot_free;
  logic           capture;
  logic           abort;

  assign fifo_in   = '{a: in_a, b: in_b};
  assign fifo_push = in_valid & ~fifo_full;

  mul4_op_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(fifo_in),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The result slot may be reused in the same cycle the consumer accepts it.
  assign slot_free = ~out_valid_reg | out_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fifo_pop   = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && mul_ready && slot_free) begin
          fifo_pop   = 1'b1;
          state_next = START;
        end
      end
      START: begin
        cnt_next   = '0;
        state_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (!mul_ready) begin
          cnt_next   = '0;
          state_next = WAIT_HI;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_HI: begin
        if (mul_ready) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands stay frozen from START until the next pop; the multiplier samples them late.
  always_comb begin
    mul_a_next = mul_a_reg;
    mul_b_next = mul_b_reg;
    if (fifo_pop) begin
      mul_a_next = fifo_head.a;
      mul_b_next = fifo_head.b;
    end
  end

  always_comb begin
    out_valid_next = out_valid_reg & ~out_ready;
    out_p_next     = out_p_reg;
    out_err_next   = out_err_reg;
    if (capture) begin
      out_valid_next = 1'b1;
      out_p_next     = mul_p;
      out_err_next   = 1'b0;
    end else if (abort) begin
      out_valid_next = 1'b1;
      out_p_next     = '0;
      out_err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_p_reg     <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      mul_a_reg     <= mul_a_next;
      mul_b_reg     <= mul_b_next;
      out_valid_reg <= out_valid_next;
      out_p_reg     <= out_p_next;
      out_err_reg   <= out_err_next;
    end
  end

  assign in_ready  = ~fifo_full;
  assign mul_start = (state_reg == START);
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign out_valid = out_valid_reg;
  assign out_p     = out_p_reg;
  assign out_err   = out_err_reg;
  assign busy      = (state_reg != IDLE) | ~fifo_empty | out_valid_reg;

endmodule
